// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, instruction field
// positions and the opcode legality check.
package alu_pkg;

  localparam logic [4:0] ADD  = 5'd4;
  localparam logic [4:0] SUB  = 5'd5;
  localparam logic [4:0] MUL  = 5'd6;
  localparam logic [4:0] DIV  = 5'd7;
  localparam logic [4:0] AND  = 5'd8;
  localparam logic [4:0] NAND = 5'd9;
  localparam logic [4:0] OR   = 5'd10;
  localparam logic [4:0] XOR  = 5'd11;
  localparam logic [4:0] CMP  = 5'd12;
  localparam logic [4:0] NOT  = 5'd13;

  localparam int unsigned OpLsb     = 0;
  localparam int unsigned OpMsb     = 4;
  localparam int unsigned RdLsb     = 5;
  localparam int unsigned RdMsb     = 9;
  localparam int unsigned Rs1Lsb    = 10;
  localparam int unsigned Rs1Msb    = 14;
  localparam int unsigned Rs2Lsb    = 15;
  localparam int unsigned Rs2Msb    = 19;
  localparam int unsigned ImmSelBit = 20;
  localparam int unsigned ImmLsb    = 21;
  localparam int unsigned ImmMsb    = 31;

  function automatic logic is_legal_op(input logic [4:0] op);
    case (op)
      ADD, SUB, MUL, DIV, AND, NAND, OR, XOR, CMP, NOT: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file with two asynchronous read ports and one synchronous write
// port; x0 reads as zero and ignores writes.
module alu_regfile #(
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned WIDTH_ADDR = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH_ADDR-1:0] raddr_a_i,
  output logic [WIDTH_DATA-1:0] rdata_a_o,
  input  logic [WIDTH_ADDR-1:0] raddr_b_i,
  output logic [WIDTH_DATA-1:0] rdata_b_o,
  input  logic                  we_i,
  input  logic [WIDTH_ADDR-1:0] waddr_i,
  input  logic [WIDTH_DATA-1:0] wdata_i
);

  logic [WIDTH_DATA-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/alu_operand_fetch.sv
// Issue stage ahead of the ALU: decode, scoreboard hazard check, operand read
// and a one-entry output register. Define WB_BYPASS_EN to forward writeback data.
module alu_operand_fetch
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned WIDTH_ADDR = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_DATA-1:0] operand_a,
  output logic [WIDTH_DATA-1:0] operand_b,
  output logic [4:0]            op_code,
  output logic [WIDTH_ADDR-1:0] out_rd,
  input  logic                  wb_valid,
  input  logic [WIDTH_ADDR-1:0] wb_addr,
  input  logic [WIDTH_DATA-1:0] wb_data,
  output logic                  illegal_op
);

  logic [4:0]            op;
  logic [WIDTH_ADDR-1:0] rd, rs1, rs2;
  logic                  imm_sel;
  logic [10:0]           imm11;
  logic [WIDTH_DATA-1:0] imm_ext;

  assign op      = instr[OpMsb:OpLsb];
  assign rd      = WIDTH_ADDR'(instr[RdMsb:RdLsb]);
  assign rs1     = WIDTH_ADDR'(instr[Rs1Msb:Rs1Lsb]);
  assign rs2     = WIDTH_ADDR'(instr[Rs2Msb:Rs2Lsb]);
  assign imm_sel = instr[ImmSelBit];
  assign imm11   = instr[ImmMsb:ImmLsb];
  assign imm_ext = {{(WIDTH_DATA-11){imm11[10]}}, imm11};

  logic [WIDTH_DATA-1:0] rf_a, rf_b;

  alu_regfile #(
    .WIDTH_DATA (WIDTH_DATA),
    .NUM_REGS   (NUM_REGS),
    .WIDTH_ADDR (WIDTH_ADDR)
  ) u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .raddr_a_i (rs1),
    .rdata_a_o (rf_a),
    .raddr_b_i (rs2),
    .rdata_b_o (rf_b),
    .we_i      (wb_valid),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data)
  );

  logic byp_a, byp_b;

`ifdef WB_BYPASS_EN
  assign byp_a = wb_valid && (wb_addr == rs1) && (rs1 != '0);
  assign byp_b = wb_valid && (wb_addr == rs2) && (rs2 != '0);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  logic [NUM_REGS-1:0]   sb_q, sb_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH_DATA-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [4:0]            op_q, op_d;
  logic [WIDTH_ADDR-1:0] rd_q, rd_d;
  logic                  illegal_q, illegal_d;

  logic legal, use_b, hazard, accept, fire;
  logic [WIDTH_DATA-1:0] src_a, src_b;

  assign legal = is_legal_op(op);
  // NOT is unary: rs2 neither read for hazards nor meaningful.
  assign use_b = ~imm_sel & (op != NOT);
  assign src_a = byp_a ? wb_data : rf_a;
  assign src_b = byp_b ? wb_data : rf_b;

  // A pending rd also stalls, keeping one op outstanding per register.
  assign hazard = legal & ((sb_q[rs1] & ~byp_a) | (use_b & sb_q[rs2] & ~byp_b) | sb_q[rd]);

  assign instr_ready = ~hazard & (~out_valid_q | out_ready);
  assign accept      = instr_valid & instr_ready;
  assign fire        = accept & legal;

  always_comb begin
    sb_d = sb_q;
    if (wb_valid) begin
      sb_d[wb_addr] = 1'b0;
    end
    if (fire) begin
      sb_d[rd] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    op_d        = op_q;
    rd_d        = rd_q;
    if (fire) begin
      out_valid_d = 1'b1;
      opa_d       = src_a;
      opb_d       = imm_sel ? imm_ext : src_b;
      op_d        = op;
      rd_d        = rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign illegal_d = accept & ~legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q        <= '0;
      out_valid_q <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      illegal_q   <= 1'b0;
    end else begin
      sb_q        <= sb_d;
      out_valid_q <= out_valid_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign operand_a  = opa_q;
  assign operand_b  = opb_q;
  assign op_code    = op_q;
  assign out_rd     = rd_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Bench for alu_operand_fetch: directed corner sequences, a vector table and a
// randomized run against a cycle-level reference model.
module tb_alu_operand_fetch;

`ifdef WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  localparam logic [4:0] OpAdd = 5'd4;
  localparam logic [4:0] OpSub = 5'd5;
  localparam logic [4:0] OpMul = 5'd6;
  localparam logic [4:0] OpAnd = 5'd8;
  localparam logic [4:0] OpOr  = 5'd10;
  localparam logic [4:0] OpXor = 5'd11;
  localparam logic [4:0] OpCmp = 5'd12;
  localparam logic [4:0] OpNot = 5'd13;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, instr_ready, out_valid, out_ready;
  logic [31:0] instr, operand_a, operand_b, wb_data;
  logic [4:0]  op_code, out_rd, wb_addr;
  logic        wb_valid, illegal_op;

  alu_operand_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .op_code     (op_code),
    .out_rd      (out_rd),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic imm_sel, input logic [10:0] imm);
    return {imm, imm_sel, rs2, rs1, rd, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_valid = 1'b0;
    instr       = '0;
    out_ready   = 1'b1;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_addr  = addr;
    wb_data  = data;
    tick();
    wb_valid = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  op, rd, rs1, rs2;
    logic        imm_sel;
    logic [10:0] imm;
    logic        exp_valid;
    logic [31:0] exp_a, exp_b;
    logic        chk_b;
  } vec_t;

  vec_t vecs [11];

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_ov, m_ill;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_op, m_rd;
  logic [4:0]  wbq [$];

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (Byp && wb_valid && wb_addr == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit m_src_busy(input logic [4:0] r);
    return m_pend[r] && !(Byp && wb_valid && wb_addr == r);
  endfunction

  initial begin
    int fire_cyc;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_operand_a", operand_a, 0);
    check("rst_operand_b", operand_b, 0);
    check("rst_op_code", op_code, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_illegal", illegal_op, 0);
    check("rst_instr_ready", instr_ready, 1);

    // First issue with sign-extended immediate
    instr = mk(OpAdd, 5'd1, 5'd0, 5'd0, 1'b1, 11'h7FF);
    instr_valid = 1'b1;
    #1 check("add_ready", instr_ready, 1);
    tick();
    check("add_valid", out_valid, 1);
    check("add_a", operand_a, 32'h0);
    check("add_b", operand_b, 32'hFFFF_FFFF);
    check("add_op", op_code, 5'd4);
    check("add_rd", out_rd, 5'd1);

    // Dependent op stalls on pending x1
    instr = mk(OpSub, 5'd2, 5'd1, 5'd0, 1'b1, 11'h0);
    #1 check("dep_stall0", instr_ready, 0);
    tick();
    #1 check("dep_stall1", instr_ready, 0);
    tick();
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
    fire_cyc = -1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (instr_ready === 1'b1 && fire_cyc < 0) fire_cyc = k;
      tick();
      wb_valid = 1'b0;
      if (fire_cyc >= 0) break;
    end
    instr_valid = 1'b0;
    check("dep_fire_cycle", fire_cyc, Byp ? 0 : 1);
    check("dep_valid", out_valid, 1);
    check("dep_a", operand_a, 32'd5);
    check("dep_rd", out_rd, 5'd2);
    wb(5'd2, 32'd9);

    // Backpressure: outputs hold, queued instruction fires on release
    out_ready = 1'b0;
    instr = mk(OpAdd, 5'd3, 5'd1, 5'd0, 1'b1, 11'd7);
    instr_valid = 1'b1;
    tick();
    instr = mk(OpOr, 5'd4, 5'd1, 5'd2, 1'b0, 11'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", instr_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_b", operand_b, 32'd7);
      check("bp_rd", out_rd, 5'd3);
      tick();
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    check("bp_next_rd", out_rd, 5'd4);
    check("bp_next_a", operand_a, 32'd5);
    check("bp_next_b", operand_b, 32'd9);
    check("bp_next_op", op_code, OpOr);
    tick();
    wb(5'd3, 32'd33);
    wb(5'd4, 32'd44);

    // x0 ignores writes
    wb(5'd0, 32'h0000_DEAD);
    instr = mk(OpAdd, 5'd0, 5'd0, 5'd0, 1'b0, 11'd0);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("x0_valid", out_valid, 1);
    check("x0_a", operand_a, 32'h0);
    check("x0_b", operand_b, 32'h0);
    tick();

    // Vector table
    wb(5'd1, 32'h0000_0011);
    wb(5'd2, 32'hFFFF_FF00);
    wb(5'd3, 32'h1234_5678);
    wb(5'd4, 32'h8000_0001);
    vecs[0]  = '{OpAdd, 5'd5, 5'd1, 5'd2, 1'b0, 11'h000, 1'b1, 32'h0000_0011, 32'hFFFF_FF00, 1'b1};
    vecs[1]  = '{OpSub, 5'd6, 5'd3, 5'd0, 1'b1, 11'h001, 1'b1, 32'h1234_5678, 32'h0000_0001, 1'b1};
    vecs[2]  = '{OpAnd, 5'd7, 5'd4, 5'd0, 1'b1, 11'h400, 1'b1, 32'h8000_0001, 32'hFFFF_FC00, 1'b1};
    vecs[3]  = '{OpNot, 5'd5, 5'd2, 5'd1, 1'b0, 11'h000, 1'b1, 32'hFFFF_FF00, 32'h0, 1'b0};
    vecs[4]  = '{5'd3,  5'd8, 5'd1, 5'd2, 1'b0, 11'h000, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[5]  = '{5'd14, 5'd8, 5'd1, 5'd2, 1'b0, 11'h000, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[6]  = '{5'd2,  5'd8, 5'd1, 5'd2, 1'b0, 11'h000, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[7]  = '{5'd20, 5'd8, 5'd1, 5'd2, 1'b0, 11'h000, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[8]  = '{OpCmp, 5'd9, 5'd8, 5'd8, 1'b0, 11'h000, 1'b1, 32'h0, 32'h0, 1'b1};
    vecs[9]  = '{OpXor, 5'd0, 5'd0, 5'd3, 1'b0, 11'h000, 1'b1, 32'h0, 32'h1234_5678, 1'b1};
    vecs[10] = '{OpMul, 5'd10, 5'd4, 5'd0, 1'b1, 11'h3FF, 1'b1, 32'h8000_0001, 32'h0000_03FF, 1'b1};
    foreach (vecs[i]) begin
      instr = mk(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm_sel, vecs[i].imm);
      instr_valid = 1'b1;
      #1 check($sformatf("vec%0d_ready", i), instr_ready, 1);
      tick();
      instr_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_illegal", i), illegal_op, !vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_a", i), operand_a, vecs[i].exp_a);
        check($sformatf("vec%0d_op", i), op_code, vecs[i].op);
        check($sformatf("vec%0d_rd", i), out_rd, vecs[i].rd);
        if (vecs[i].chk_b) check($sformatf("vec%0d_b", i), operand_b, vecs[i].exp_b);
      end
      wb_valid = vecs[i].exp_valid;
      wb_addr  = vecs[i].rd;
      wb_data  = 32'h0;
      tick();
      wb_valid = 1'b0;
      check($sformatf("vec%0d_illegal_end", i), illegal_op, 0);
    end

    // Asynchronous reset with an op in flight
    out_ready = 1'b0;
    instr = mk(OpAdd, 5'd6, 5'd1, 5'd0, 1'b1, 11'd3);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    check("mid_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_a", operand_a, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    instr = mk(OpAdd, 5'd6, 5'd1, 5'd3, 1'b0, 11'd0);
    instr_valid = 1'b1;
    #1 check("post_rst_ready", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    check("post_rst_valid", out_valid, 1);
    check("post_rst_a", operand_a, 0);
    check("post_rst_b", operand_b, 0);

    // Randomized run against the reference model
    do_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
    m_ov = 1'b0; m_ill = 1'b0;
    m_a = '0; m_b = '0; m_op = '0; m_rd = '0;
    for (int c = 0; c < 600; c++) begin
      logic [4:0] op, rd, rs1, rs2, wr;
      logic       imm_sel, legal, use_b, hazard, exp_ready, fire;
      logic [10:0] imm;
      op      = 5'($urandom_range(0, 15));
      rd      = 5'($urandom_range(0, 7));
      rs1     = 5'($urandom_range(0, 7));
      rs2     = 5'($urandom_range(0, 7));
      imm_sel = 1'($urandom_range(0, 1));
      imm     = 11'($urandom);
      instr       = mk(op, rd, rs1, rs2, imm_sel, imm);
      instr_valid = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      wb_valid    = 1'b0;
      if (wbq.size() > 0 && $urandom_range(0, 1) == 1) begin
        wb_valid = 1'b1;
        wb_addr  = wbq.pop_front();
        wb_data  = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        wr = 5'($urandom_range(0, 7));
        if (!m_pend[wr]) begin
          wb_valid = 1'b1;
          wb_addr  = wr;
          wb_data  = $urandom;
        end
      end
      #1;
      legal     = (op >= 5'd4) && (op <= 5'd13);
      use_b     = !imm_sel && (op != OpNot);
      hazard    = legal && (m_src_busy(rs1) || (use_b && m_src_busy(rs2)) || m_pend[rd]);
      exp_ready = !hazard && (!m_ov || out_ready);
      check("rnd_ready", instr_ready, exp_ready);
      fire  = instr_valid && exp_ready && legal;
      m_ill = instr_valid && exp_ready && !legal;
      if (m_ov && out_ready && m_rd != 0) wbq.push_back(m_rd);
      if (fire) begin
        m_a  = m_read(rs1);
        m_b  = imm_sel ? {{21{imm[10]}}, imm} : m_read(rs2);
        m_op = op;
        m_rd = rd;
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (wb_valid) begin
        if (wb_addr != 0) m_regs[wb_addr] = wb_data;
        m_pend[wb_addr] = 1'b0;
      end
      if (fire && rd != 0) m_pend[rd] = 1'b1;
      tick();
      check("rnd_valid", out_valid, m_ov);
      check("rnd_illegal", illegal_op, m_ill);
      if (m_ov) begin
        check("rnd_a", operand_a, m_a);
        check("rnd_b", operand_b, m_b);
        check("rnd_op", op_code, m_op);
        check("rnd_rd", out_rd, m_rd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_fetch.md
Name: alu_operand_fetch

Overview:
- Issue stage directly upstream of the ALU.
- Accepts instruction words over a valid/ready handshake and reads operands from an internal register file.
- Tracks pending destination registers in a scoreboard.
- Presents registered operand_a, operand_b and op_code to the ALU over a valid/ready output, and accepts ALU results back on a writeback port.

Parameters:
- WIDTH_DATA, 32, operand/register width.
- NUM_REGS, 32, register file depth; power of two, max 32.
- WIDTH_ADDR, 5, register index width; must equal log2(NUM_REGS).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  stage accepts instruction this cycle.
- instr  in  32  [4:0] op_code, [9:5] rd, [14:10] rs1, [19:15] rs2, [20] imm_sel, [31:21] imm11.
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  downstream accepts.
- operand_a  out  WIDTH_DATA  to ALU.
- operand_b  out  WIDTH_DATA  to ALU.
- op_code  out  5  to ALU.
- out_rd  out  WIDTH_ADDR  destination tag travelling with the op.
- wb_valid  in  1  writeback strobe.
- wb_addr  in  WIDTH_ADDR  writeback register.
- wb_data  in  WIDTH_DATA  ALU result.
- illegal_op  out  1  one-cycle pulse when an illegal opcode is consumed.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, operand_a/operand_b/op_code/out_rd=0, illegal_op=0.
  - All registers=0; scoreboard=0.
  - instr_ready is combinational and evaluates to 1 after reset.
- Legal opcodes are 4..13; all others are illegal.
- Illegal opcode:
  - Accepted when instr_valid=1 and the stage is not stalled.
  - Dropped with no issue and no scoreboard set.
  - illegal_op=1 for the following cycle.
- Register x0:
  - Reads return 0.
  - Writes are ignored.
  - Never marked pending.
- Operand selection:
  - operand_a = R[rs1].
  - operand_b = imm_sel ? sign-extend(imm11) to WIDTH_DATA : R[rs2].
  - For op_code 13 (NOT), rs2/imm are ignored and not hazard-checked.
- Hazard: stall if scoreboard[rs1], or scoreboard[rs2] with imm_sel=0 and op != NOT.
  - A source cleared by a wb_valid in the same cycle is not a hazard; see Optional Feature.
- Output register (one entry, one cycle latency):
  - Fire = instr_valid & instr_ready & legal & no hazard.
  - instr_ready = ~hazard & (~out_valid | out_ready).
  - On fire, the output register loads, out_valid=1, and scoreboard[rd] is set if rd != 0.
  - When out_valid & out_ready with no new fire, out_valid goes to 0.
  - Output fields hold stable while out_valid & ~out_ready.
- Writeback:
  - wb_valid writes R[wb_addr] and clears scoreboard[wb_addr] at the clock edge.
  - Same-edge set (new issue to rd) and clear (wb to the same addr): set wins.
- Write-after-write:
  - An instruction whose rd is pending stalls.
  - This guarantees single-outstanding per register.
- Reset mid-operation clears the in-flight op; any later wb for it is written to the register but clears an already-clear bit (harmless).

Optional Feature:
- WB_BYPASS_EN defined:
  - A source matching wb_addr with wb_valid=1 in the issue cycle takes wb_data combinationally.
  - It is treated as not hazarded.
  - Gives zero-bubble back-to-back dependent ops.
- Not defined:
  - Such a source stalls one cycle.
  - It reads the register file next cycle.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams ADD=4, SUB=5, MUL=6, DIV=7, AND=8, NAND=9, OR=10, XOR=11, CMP=12, NOT=13.
  - instruction field bit positions.
  - opcode-legal check function.
- One sub-module, alu_regfile: 2 async read ports, 1 sync write port, x0 hardwired, async reset.

Test Plan:
- Reset then issue ADD rd=1, rs1=0, imm_sel=1, imm11=0x7FF:
  - next cycle out_valid=1, operand_a=0, operand_b=0xFFFFFFFF, op_code=4, out_rd=1.
  - scoreboard[1]=1.
- Dependent op SUB rd=2, rs1=1 while x1 pending:
  - instr_ready=0 until wb_valid addr=1 data=5.
  - With bypass, fire in the wb cycle with operand_a=5; without bypass, one cycle later.
- Backpressure: out_ready=0 for 3 cycles after issue:
  - outputs hold.
  - instr_ready=0.
  - after out_ready=1, the next queued instr fires the same cycle.
- Illegal op_code=2, then op_code=20:
  - each gives a one-cycle illegal_op pulse.
  - out_valid stays 0; no scoreboard change.
- Write to x0 via wb_valid addr=0 data=0xDEAD, then read rs1=0 → operand_a=0.
- Assert rst while out_valid=1 and scoreboard non-zero:
  - out_valid=0 and scoreboard=0 immediately (asynchronously).
  - registers read 0 afterwards.
